// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if
//   Bundles every handshake and bus signal between the rv32i core, the
//   unified instruction/data memory and unified_mem_arbiter.
//   slave  : the arbiter's view. It takes the requests and mem_rdata, and
//            drives the grants, read returns, memory controls and busy.
//   master : the environment's view (core plus memory), the mirror of slave.
//   Signals:
//     if_req/if_addr -> if_gnt, if_rvalid, if_rdata       fetch port
//     d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid, d_rdata   load/store port
//     mem_en/mem_we/mem_addr/mem_wdata -> mem_rdata        memory port
//     busy                                                 read outstanding
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-port synchronous memory between the instruction-fetch
//   and load/store ports of the rv32i core. One requester is granted per
//   access. Writes complete in the grant cycle. A read waits MEM_LAT cycles,
//   and its data is then returned to the port that issued it. Data wins any
//   tie, but a fetch that has lost STARVE_MAX arbitrations in a row wins the
//   next one.
//   Ports:
//     clk  - single clock, rising edge
//     rst  - asynchronous active-low reset
//     bus  - unified_mem_arbiter_if.slave (requests, grants, read returns,
//            memory port, busy)
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  unified_mem_arbiter_if.slave bus
);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;      // 1 = data port owns the read
  logic [STV_W-1:0]  starve_q, starve_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic              busy_q, busy_d;

  logic fetch_win, data_win;

  // Fetch wins when it is alone, or when it has been starved long enough.
  always_comb begin
    fetch_win = 1'b0;
    data_win  = 1'b0;
    if (state_q == IDLE) begin
      fetch_win = bus.if_req && (!bus.d_req || (starve_q == STV_MAX));
      data_win  = bus.d_req && !fetch_win;
    end
  end

  assign bus.if_gnt    = fetch_win;
  assign bus.d_gnt     = data_win;
  assign bus.mem_en    = fetch_win | data_win;
  assign bus.mem_we    = data_win & bus.d_we;
  assign bus.mem_addr  = fetch_win ? bus.if_addr :
                         (data_win ? bus.d_addr : '0);
  assign bus.mem_wdata = data_win ? bus.d_wdata : '0;

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = busy_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Starvation count only moves while arbitration is possible.
        if (!bus.if_req || fetch_win) begin
          starve_d = '0;
        end else if (starve_q != STV_MAX) begin
          starve_d = starve_q + 1'b1;
        end

        // Writes finish in the grant cycle; only reads enter WAIT.
        if (fetch_win || (data_win && !bus.d_we)) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
          owner_d = data_win;
        end
      end

      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (owner_q) begin
            d_rdata_d  = bus.mem_rdata;
            d_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = bus.mem_rdata;
            if_rvalid_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      starve_q    <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      busy_q      <= busy_d;
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter
//   Drives four arbiters (MEM_LAT = 1..4, STARVE_MAX = 4). Each one has its own
//   memory model. Request enables are per-instance masks, so a scenario can
//   target a single latency. Read returns of the MEM_LAT=1 instance go to a
//   scoreboard of expected owner/data pairs.
module tb_unified_mem_arbiter;
  logic clk;
  logic rst;

  logic [3:0]  if_req_v, d_req_v;
  logic        d_we;
  logic [31:0] if_addr, d_addr, d_wdata;

  logic [3:0]  if_gnt_v, d_gnt_v, if_rvalid_v, d_rvalid_v, busy_v, mem_en_v, mem_we_v;
  logic [31:0] if_rdata_v [4];
  logic [31:0] d_rdata_v [4];
  logic [31:0] mem_addr_v [4];
  logic [31:0] mem_wdata_v [4];

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        owner;   // 1 = data port
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    assign bus.if_req  = if_req_v[k];
    assign bus.if_addr = if_addr;
    assign bus.d_req   = d_req_v[k];
    assign bus.d_we    = d_we;
    assign bus.d_addr  = d_addr;
    assign bus.d_wdata = d_wdata;

    assign if_gnt_v[k]    = bus.if_gnt;
    assign d_gnt_v[k]     = bus.d_gnt;
    assign if_rvalid_v[k] = bus.if_rvalid;
    assign d_rvalid_v[k]  = bus.d_rvalid;
    assign busy_v[k]      = bus.busy;
    assign mem_en_v[k]    = bus.mem_en;
    assign mem_we_v[k]    = bus.mem_we;
    assign if_rdata_v[k]  = bus.if_rdata;
    assign d_rdata_v[k]   = bus.d_rdata;
    assign mem_addr_v[k]  = bus.mem_addr;
    assign mem_wdata_v[k] = bus.mem_wdata;

    unified_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(k + 1), .STARVE_MAX(4)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    // Memory model: word-addressed, read data valid exactly k+1 cycles after
    // the read cycle and a poison value at any other time.
    logic [31:0] mem [64];
    logic [5:0]  apipe [4];
    logic [3:0]  vpipe;

    initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
      mem[1] = 32'h0050_0093;
      vpipe  = 4'b0;
      for (int i = 0; i < 4; i++) apipe[i] = 6'd0;
    end

    always @(posedge clk) begin
      apipe[0] <= bus.mem_addr[7:2];
      vpipe[0] <= bus.mem_en && !bus.mem_we;
      for (int j = 1; j < 4; j++) begin
        apipe[j] <= apipe[j-1];
        vpipe[j] <= vpipe[j-1];
      end
      if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    assign bus.mem_rdata = vpipe[k] ? mem[apipe[k]] : 32'hBAD0_BAD0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] ifm, input logic [3:0] dm,
                               input logic we, input logic [31:0] ia,
                               input logic [31:0] da, input logic [31:0] wd);
    if_req_v = ifm;
    d_req_v  = dm;
    d_we     = we;
    if_addr  = ia;
    d_addr   = da;
    d_wdata  = wd;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the MEM_LAT=1 instance.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && (if_rvalid_v[0] || d_rvalid_v[0])) begin
      checkOutput("rvalid_exclusive", 32'(if_rvalid_v[0] & d_rvalid_v[0]), 32'd0);
      checkOutput("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput("sb_owner", 32'(d_rvalid_v[0]), 32'(e.owner));
        checkOutput("sb_rdata", d_rvalid_v[0] ? d_rdata_v[0] : if_rdata_v[0], e.data);
      end
    end
  end

  initial begin : stim
    logic       seen;
    logic [3:0] exp_rv, exp_bz;

    rst = 1'b0;
    applyStimulus(4'b0, 4'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy_v), 32'd0);
    checkOutput("rst_rvalid", 32'({if_rvalid_v, d_rvalid_v}), 32'd0);
    checkOutput("rst_if_rdata", if_rdata_v[0], 32'd0);
    checkOutput("rst_d_rdata", d_rdata_v[0], 32'd0);
    checkOutput("rst_mem_en", 32'(mem_en_v), 32'd0);
    nextCycle();
    rst = 1'b1;

    // Reset in the middle of a MEM_LAT=2 fetch.
    nextCycle();
    applyStimulus(4'b0010, 4'b0, 1'b0, 32'h10, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("midrst_gnt", 32'(if_gnt_v[1]), 32'd1);
    nextCycle();
    applyStimulus(4'b0, 4'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("midrst_busy_before", 32'(busy_v[1]), 32'd1);
    rst  = 1'b0;
    seen = 1'b0;
    #1;
    checkOutput("midrst_busy_after", 32'(busy_v), 32'd0);
    checkOutput("midrst_gnt_after", 32'({if_gnt_v, d_gnt_v}), 32'd0);
    nextCycle();
    seen = seen | if_rvalid_v[1];
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      seen = seen | if_rvalid_v[1];
      nextCycle();
    end
    checkOutput("midrst_no_rvalid", 32'(seen), 32'd0);

    // Single fetch, MEM_LAT=1.
    sb_q.push_back({1'b0, 32'h0050_0093});
    applyStimulus(4'b0001, 4'b0, 1'b0, 32'h4, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("fetch_gnt", 32'({if_gnt_v[0], d_gnt_v[0], mem_en_v[0], mem_we_v[0]}), 32'b1010);
    checkOutput("fetch_mem_addr", mem_addr_v[0], 32'h4);
    checkOutput("fetch_mem_wdata", mem_wdata_v[0], 32'h0);
    nextCycle();
    applyStimulus(4'b0, 4'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("fetch_g1_rvalid", 32'(if_rvalid_v[0]), 32'd0);
    checkOutput("fetch_g1_busy", 32'(busy_v[0]), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("fetch_g2_rvalid", 32'({if_rvalid_v[0], d_rvalid_v[0]}), 32'b10);
    checkOutput("fetch_g2_rdata", if_rdata_v[0], 32'h0050_0093);
    checkOutput("fetch_g2_busy", 32'(busy_v[0]), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("fetch_g3_rvalid", 32'(if_rvalid_v[0]), 32'd0);
    checkOutput("fetch_g3_hold", if_rdata_v[0], 32'h0050_0093);

    // Data write then read of 0x80.
    nextCycle();
    applyStimulus(4'b0, 4'b0001, 1'b1, 32'h0, 32'h80, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("wr_gnt", 32'({d_gnt_v[0], if_gnt_v[0], mem_we_v[0]}), 32'b101);
    checkOutput("wr_mem_addr", mem_addr_v[0], 32'h80);
    checkOutput("wr_mem_wdata", mem_wdata_v[0], 32'hDEAD_BEEF);
    nextCycle();
    sb_q.push_back({1'b1, 32'hDEAD_BEEF});
    applyStimulus(4'b0, 4'b0001, 1'b0, 32'h0, 32'h80, 32'h0);
    @(negedge clk);
    checkOutput("rd_gnt", 32'({d_gnt_v[0], mem_we_v[0], d_rvalid_v[0]}), 32'b100);
    checkOutput("rd_mem_wdata", mem_wdata_v[0], 32'h0);
    nextCycle();
    applyStimulus(4'b0, 4'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rd_g1", 32'({busy_v[0], d_rvalid_v[0]}), 32'b10);
    nextCycle();
    @(negedge clk);
    checkOutput("rd_g2_rvalid", 32'({d_rvalid_v[0], if_rvalid_v[0]}), 32'b10);
    checkOutput("rd_g2_rdata", d_rdata_v[0], 32'hDEAD_BEEF);
    repeat (2) nextCycle();

    // Simultaneous fetch (0x8) and data read (0x80).
    sb_q.push_back({1'b1, 32'hDEAD_BEEF});
    sb_q.push_back({1'b0, 32'h1000_0002});
    applyStimulus(4'b0001, 4'b0001, 1'b0, 32'h8, 32'h80, 32'h0);
    @(negedge clk);
    checkOutput("sim_g0", 32'({d_gnt_v[0], if_gnt_v[0]}), 32'b10);
    nextCycle();
    applyStimulus(4'b0001, 4'b0, 1'b0, 32'h8, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("sim_g1", 32'({d_gnt_v[0], if_gnt_v[0], busy_v[0]}), 32'b001);
    nextCycle();
    @(negedge clk);
    checkOutput("sim_g2", 32'({d_rvalid_v[0], if_gnt_v[0], mem_addr_v[0] == 32'h8}), 32'b111);
    nextCycle();
    applyStimulus(4'b0, 4'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("sim_g4", 32'({if_rvalid_v[0], d_rvalid_v[0]}), 32'b10);
    checkOutput("sim_d_hold", d_rdata_v[0], 32'hDEAD_BEEF);
    repeat (2) nextCycle();

    // Starvation guard: data writes and fetches held high together.
    applyStimulus(4'b0001, 4'b0001, 1'b1, 32'h4, 32'h40, 32'h55);
    for (int r = 0; r < 2; r++) begin
      for (int c = 1; c <= 6; c++) begin
        if (c == 5) sb_q.push_back({1'b0, 32'h0050_0093});
        @(negedge clk);
        checkOutput($sformatf("starve_r%0d_c%0d", r, c),
                    32'({d_gnt_v[0], if_gnt_v[0]}),
                    32'({c <= 4, c == 5}));
        nextCycle();
      end
    end
    applyStimulus(4'b0, 4'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (3) nextCycle();

    // Latency sweep: the same fetch on all four instances at once.
    sb_q.push_back({1'b0, 32'h0050_0093});
    applyStimulus(4'b1111, 4'b0, 1'b0, 32'h4, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("sweep_gnt", 32'(if_gnt_v), 32'hF);
    for (int c = 1; c <= 6; c++) begin
      nextCycle();
      if (c == 1) applyStimulus(4'b0, 4'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        exp_rv[k] = (c == k + 2);
        exp_bz[k] = (c <= k + 1);
      end
      checkOutput($sformatf("sweep_rvalid_c%0d", c), 32'(if_rvalid_v), 32'(exp_rv));
      checkOutput($sformatf("sweep_busy_c%0d", c), 32'(busy_v), 32'(exp_bz));
    end
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("sweep_rdata_%0d", k), if_rdata_v[k], 32'h0050_0093);

    nextCycle();
    @(negedge clk);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
